// File: rtl/segway_pkg.sv
// rtl/segway_pkg.sv - shared rider-state type and default load thresholds.
package segway_pkg;

   typedef enum logic [1:0] {
      NORIDER = 2'd0,
      WAIT    = 2'd1,
      STEER   = 2'd2
   } rider_state_t;

   localparam logic [11:0] MIN_RIDER_WT_DEF = 12'h200;
   localparam logic [11:0] WT_HYST_DEF      = 12'h040;

endpackage

// File: rtl/rider_detect_ld_compare.sv
// rtl/rider_detect_ld_compare.sv - combinational load sum/balance classification.
module ld_compare
   import segway_pkg::*;
#(
   parameter logic [11:0] MIN_RIDER_WT = MIN_RIDER_WT_DEF,
   parameter logic [11:0] WT_HYST      = WT_HYST_DEF
) (
   input  logic [11:0] i_lft_q,
   input  logic [11:0] i_rght_q,
   output logic        o_present,
   output logic        o_gone,
   output logic        o_unbal_lo,
   output logic        o_unbal_hi
);

   localparam logic [12:0] PRESENT_WT = {1'b0, MIN_RIDER_WT};
   localparam logic [12:0] GONE_WT    = {1'b0, MIN_RIDER_WT - WT_HYST};

   logic [12:0] w_sum;
   logic [11:0] w_diff;

   assign w_sum  = {1'b0, i_lft_q} + {1'b0, i_rght_q};
   // Subtract the smaller from the larger so the magnitude never wraps.
   assign w_diff = (i_lft_q >= i_rght_q) ? (i_lft_q - i_rght_q) : (i_rght_q - i_lft_q);

   assign o_present  = (w_sum > PRESENT_WT);
   assign o_gone     = (w_sum < GONE_WT);
   assign o_unbal_lo = ({1'b0, w_diff} > (w_sum >> 2));
   assign o_unbal_hi = ({1'b0, w_diff} > (w_sum - (w_sum >> 4)));

endmodule

// File: rtl/rider_detect.sv
// rtl/rider_detect.sv - rider presence/steer-qualify FSM; RIDER_DETECT_FAST_SIM_EN shortens the dwell to 2^15 clocks.
module rider_detect
   import segway_pkg::*;
#(
   parameter logic [11:0] MIN_RIDER_WT = MIN_RIDER_WT_DEF,
   parameter logic [11:0] WT_HYST      = WT_HYST_DEF,
   parameter int          TMR_BITS     = 26
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [11:0] lft_ld,
   input  logic [11:0] rght_ld,
   input  logic        ld_vld,
   output logic        rider_off,
   output logic        en_steer
);

`ifdef RIDER_DETECT_FAST_SIM_EN
   localparam int DONE_BITS = (TMR_BITS < 15) ? TMR_BITS : 15;
`else
   localparam int DONE_BITS = TMR_BITS;
`endif

   logic [11:0]         r_lft_q;
   logic [11:0]         r_rght_q;
   logic [TMR_BITS-1:0] r_tmr;
   rider_state_t        r_state;
   rider_state_t        w_nxt_state;
   logic                w_present;
   logic                w_gone;
   logic                w_unbal_lo;
   logic                w_unbal_hi;
   logic                w_tmr_clr;
   logic                w_tmr_inc;
   logic                w_tmr_done;

   ld_compare #(
      .MIN_RIDER_WT (MIN_RIDER_WT),
      .WT_HYST      (WT_HYST)
   ) u_ld_compare (
      .i_lft_q    (r_lft_q),
      .i_rght_q   (r_rght_q),
      .o_present  (w_present),
      .o_gone     (w_gone),
      .o_unbal_lo (w_unbal_lo),
      .o_unbal_hi (w_unbal_hi)
   );

   assign w_tmr_done = &r_tmr[DONE_BITS-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lft_q  <= '0;
         r_rght_q <= '0;
      end else if (ld_vld) begin
         r_lft_q  <= lft_ld;
         r_rght_q <= rght_ld;
      end
   end

   always_comb begin
      w_nxt_state = r_state;
      w_tmr_clr   = 1'b0;
      w_tmr_inc   = 1'b0;
      case (r_state)
         NORIDER: begin
            if (w_present) begin
               w_nxt_state = WAIT;
               w_tmr_clr   = 1'b1;
            end
         end
         WAIT: begin
            if (w_gone) begin
               w_nxt_state = NORIDER;
            end else if (w_unbal_lo) begin
               w_tmr_clr = 1'b1;
            end else if (w_tmr_done) begin
               w_nxt_state = STEER;
            end else begin
               w_tmr_inc = 1'b1;
            end
         end
         STEER: begin
            if (w_gone) begin
               w_nxt_state = NORIDER;
            end else if (w_unbal_hi) begin
               w_nxt_state = WAIT;
               w_tmr_clr   = 1'b1;
            end
         end
         default: w_nxt_state = NORIDER;
      endcase
   end

   // Increment is only requested while not done, so the timer saturates.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tmr <= '0;
      end else if (w_tmr_clr) begin
         r_tmr <= '0;
      end else if (w_tmr_inc) begin
         r_tmr <= r_tmr + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= NORIDER;
         rider_off <= 1'b1;
         en_steer  <= 1'b0;
      end else begin
         r_state   <= w_nxt_state;
         rider_off <= (w_nxt_state == NORIDER);
         en_steer  <= (w_nxt_state == STEER);
      end
   end

endmodule

// File: tb/tb_rider_detect.sv
// tb/tb_rider_detect.sv - scoreboard bench for rider_detect with a short qualification timer.
module tb_rider_detect;

   localparam int TB_TMR_BITS = 10;
   localparam int DWELL       = 1 << TB_TMR_BITS;
   localparam int MIN_WT      = 'h200;
   localparam int HYST        = 'h040;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [11:0] lft_ld = '0;
   logic [11:0] rght_ld = '0;
   logic        ld_vld = 1'b0;
   logic        rider_off;
   logic        en_steer;

   int n_cmp = 0;
   int n_bad = 0;
   logic [1:0] exp_q[$];

   always #5 clk = ~clk;

   rider_detect #(.TMR_BITS(TB_TMR_BITS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .lft_ld    (lft_ld),
      .rght_ld   (rght_ld),
      .ld_vld    (ld_vld),
      .rider_off (rider_off),
      .en_steer  (en_steer)
   );

   // Reference model: 0 = no rider, 1 = qualifying, 2 = steering.
   int m_st = 0;
   int m_l = 0;
   int m_r = 0;
   int m_balanced = 0;
   int m_sum, m_diff;

   always @(negedge rst_n) begin
      m_st = 0; m_l = 0; m_r = 0; m_balanced = 0;
   end

   always @(posedge clk) begin
      if (!rst_n) begin
         m_st = 0; m_l = 0; m_r = 0; m_balanced = 0;
      end else begin
         m_sum  = m_l + m_r;
         m_diff = (m_l > m_r) ? m_l - m_r : m_r - m_l;
         case (m_st)
            0: if (m_sum > MIN_WT) begin m_st = 1; m_balanced = 0; end
            1: begin
               if (m_sum < MIN_WT - HYST) m_st = 0;
               else if (m_diff > m_sum / 4) m_balanced = 0;
               else if (m_balanced == DWELL - 1) m_st = 2;
               else m_balanced = m_balanced + 1;
            end
            default: begin
               if (m_sum < MIN_WT - HYST) m_st = 0;
               else if (m_diff > m_sum - m_sum / 16) begin m_st = 1; m_balanced = 0; end
            end
         endcase
         if (ld_vld) begin m_l = lft_ld; m_r = rght_ld; end
      end
      exp_q.push_back({m_st == 0, m_st == 2});
   end

   logic [1:0] mon_exp;
   int         cyc = 0;
   always @(negedge clk) begin
      cyc++;
      if (exp_q.size() > 0) begin
         mon_exp = exp_q.pop_front();
         n_cmp++;
         if ({rider_off, en_steer} !== mon_exp) begin
            n_bad++;
            $display("FAIL outputs cyc=%0d: rider_off=%b en_steer=%b, expected rider_off=%b en_steer=%b",
                     cyc, rider_off, en_steer, mon_exp[1], mon_exp[0]);
         end
      end
   end

   task automatic run(input logic [11:0] l, input logic [11:0] r, input int n, input int vld_pct);
      repeat (n) begin
         @(negedge clk);
         lft_ld  = l;
         rght_ld = r;
         ld_vld  = ($urandom_range(99) < vld_pct);
      end
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if (rider_off !== 1'b1 || en_steer !== 1'b0) begin
         n_bad++;
         $display("FAIL async_reset: rider_off=%b en_steer=%b, expected 1 0", rider_off, en_steer);
      end
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b1;
   endtask

   int          mode;
   int          seg_len;
   logic [11:0] a, b;

   initial begin
      #23 rst_n = 1'b1;
      run(12'h000, 12'h000, 100, 100);
      run(12'h180, 12'h180, DWELL + 20, 100);
      run(12'h000, 12'h000, 5, 100);
      run(12'h180, 12'h180, 300, 100);
      run(12'h300, 12'h080, 600, 100);
      run(12'h180, 12'h180, DWELL + 20, 100);
      run(12'h300, 12'h040, 50, 100);
      run(12'h3F8, 12'h008, 10, 100);
      run(12'h180, 12'h180, DWELL + 20, 100);
      run(12'h0F0, 12'h0F0, 30, 100);
      run(12'h0D8, 12'h0D8, 10, 100);
      run(12'h180, 12'h180, 500, 100);
      pulse_reset();
      run(12'h180, 12'h180, DWELL + 20, 100);

      for (int seg = 0; seg < 30; seg++) begin
         mode    = $urandom_range(5);
         seg_len = $urandom_range(1, DWELL + 200);
         case (mode)
            0: begin a = 12'($urandom_range('hD0)); b = 12'($urandom_range('hD0)); end
            1: begin
               a = 12'($urandom_range('h1C0, 'h200));
               b = a - (a >> 1);
               a = a >> 1;
            end
            2: begin a = 12'($urandom_range('h110, 'h700)); b = a + 12'($urandom_range(6)); end
            3: begin a = 12'($urandom_range('h200, 'h600)); b = a / 3; end
            4: begin a = 12'($urandom_range('h300, 'h800)); b = 12'($urandom_range(8)); end
            default: begin a = 12'($urandom_range('hFFF)); b = 12'($urandom_range('hFFF)); end
         endcase
         if ($urandom_range(9) == 0) pulse_reset();
         for (int k = 0; k < seg_len; k++) begin
            run(a + 12'($urandom_range(3)), b, 1, 30);
         end
      end

      run(12'h000, 12'h000, 5, 100);
      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/rider_detect.md
Name: rider_detect

Overview:
- Conditions the left/right platform load-cell readings into the rider_off flag consumed by the authentication/power state machine.
- Also produces en_steer, which gates steering once the rider has stood balanced for a qualification period.
- Sits between the A2D load-cell interface (upstream) and the auth/power and steering logic (downstream).
- Uses a three-state FSM, a qualification timer, and registered load samples with hysteresis.

Parameters:
- MIN_RIDER_WT, 12'h200: rider-present threshold on the load sum.
- WT_HYST, 12'h040: hysteresis below MIN_RIDER_WT before the rider is declared off. Must be less than MIN_RIDER_WT.
- TMR_BITS, 26: qualification timer width; dwell is 2^TMR_BITS clocks, about 1.34 s at 50 MHz.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- lft_ld  in  12  left load-cell reading, unsigned
- rght_ld  in  12  right load-cell reading, unsigned
- ld_vld  in  1  one-cycle strobe; lft_ld/rght_ld valid this cycle
- rider_off  out  1  registered; high when no rider is present
- en_steer  out  1  registered; high when the rider is qualified and balanced

Behaviour:
- Interface (decided): single clock clk; asynchronous active-low reset rst_n. All flops reset on the falling edge of rst_n.
- Reset values:
  - State NORIDER; rider_off=1; en_steer=0.
  - Timer=0; sample registers=0.
- Sampling:
  - lft_ld/rght_ld are captured into lft_q/rght_q on the clk edge where ld_vld=1. Otherwise they hold.
  - All comparisons use the registered samples only.
- Arithmetic:
  - sum = lft_q + rght_q, 13-bit, no overflow.
  - diff = |lft_q - rght_q|, 12-bit, computed without sign wrap.
  - present = sum > MIN_RIDER_WT, strictly greater.
  - gone = sum < MIN_RIDER_WT - WT_HYST.
  - unbal_lo = diff > (sum >> 2), i.e. above 1/4 of sum.
  - unbal_hi = diff > (sum - (sum >> 4)), i.e. above 15/16 of sum.
- FSM, evaluated every clk:
  - NORIDER: if present, go to WAIT and clear the timer. Otherwise stay.
  - WAIT:
    - If gone, go to NORIDER.
    - Else if unbal_lo, clear the timer and stay.
    - Else if the timer is all-ones, go to STEER.
    - Else increment the timer.
  - STEER: if gone, go to NORIDER. Else if unbal_hi, go to WAIT and clear the timer. Otherwise stay.
  - Priority within a state: gone > unbalance > timer.
- Outputs:
  - Decoded from nxt_state into flops, so each output changes on the same edge the state is entered.
  - rider_off = (state==NORIDER).
  - en_steer = (state==STEER).
- Latency:
  - A sample arriving with ld_vld at edge N is registered at N.
  - That sample can change state and outputs at edge N+1.
- Timer:
  - Saturating: it never wraps past all-ones.
  - It is not incremented outside WAIT.
  - Minimum WAIT dwell is 2^TMR_BITS clocks of balanced samples.
- Boundary conditions:
  - sum exactly equal to MIN_RIDER_WT is not present.
  - sum in [MIN_RIDER_WT-WT_HYST, MIN_RIDER_WT] holds the current state's rider decision (hysteresis band).
  - sum=0 yields unbal_lo=0 and unbal_hi=0.
  - Reset asserted mid-WAIT or mid-STEER returns immediately to reset values. There is no partial-timer retention.

Optional Feature:
- Macro: RIDER_DETECT_FAST_SIM_EN.
- Defined: the timer done condition uses only the low 15 bits (dwell 32768 clocks) so simulations complete quickly. The timer register width is unchanged.
- Undefined: the full TMR_BITS compare is used.
- No other behaviour differs between the two builds.

Decomposition:
- Shared package segway_pkg holds:
  - the state enum type rider_state_t {NORIDER, WAIT, STEER};
  - the default MIN_RIDER_WT and WT_HYST constants, reused by the steering and auth blocks.
- One natural sub-module: ld_compare. It is combinational and takes lft_q and rght_q. It produces sum, present, gone, unbal_lo and unbal_hi.
- The FSM, timer and sample registers stay in rider_detect.

Test Plan (RIDER_DETECT_FAST_SIM_EN defined):
- Reset, then ld_vld with lft=rght=0 -> rider_off=1, en_steer=0, held for 100 cycles.
- Balanced rider: lft=rght=12'h180 with ld_vld -> rider_off falls at the 2nd edge. en_steer rises exactly 32768 clocks after entering WAIT.
- Imbalance in WAIT: lft=12'h300, rght=12'h080 (diff=0x280 > 0x380>>2=0xE0) for 20000 clocks, then balanced -> timer restarts. en_steer rises 32768 clocks after rebalancing.
- STEER holds at moderate imbalance: lft=12'h300, rght=12'h040 -> en_steer stays 1. Then lft=12'h3F8, rght=12'h008 (diff 0x3F0 > 0x3C0) -> en_steer=0, state WAIT, rider_off stays 0.
- Hysteresis: from STEER, sum=0x1E0 (in band) -> no change. sum=0x1B0 (< 0x1C0) -> rider_off=1, en_steer=0 next edge.
- Reset mid-WAIT at timer≈16000 -> immediate rider_off=1. A fresh rider needs a full 32768 clocks to reach STEER.
